// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte transmit scheduler: FSM encoding,
// default framing timing and the serialised word width.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } spi_state_t;

    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_DEF_CLK_DIV = 2;
    localparam int SPI_DEF_CS_GAP  = 2;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting at ptr,
// with ptr advancing past the winner whenever a grant is taken.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       adv,
    output logic                       vld,
    output logic [NUM_REQ-1:0]         win_oh,
    output logic [$clog2(NUM_REQ)-1:0] win_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] scan_idx;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(NUM_REQ))
            s = s - (IDX_W+1)'(NUM_REQ);
        return s[IDX_W-1:0];
    endfunction

    // First pending requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        vld      = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_add(ptr, IDX_W'(k));
            if (!vld && req[scan_idx]) begin
                vld     = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int k = 0; k < NUM_REQ; k++)
            win_oh[k] = vld && (win_idx == IDX_W'(k));
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= wrap_add(win_idx, IDX_W'(1));
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Shares one SPI byte transmitter between NUM_REQ sources: round-robin
// grant, latched byte serialised with mode-0 clocking and a CS gap.
module spi_tx_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_DIV   = SPI_DEF_CLK_DIV,
    parameter int CS_GAP    = SPI_DEF_CS_GAP,
    parameter int LSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [SPI_BYTE_W*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy,
    output logic                          done,
    output logic                          out,
    output logic                          en_out,
    output logic                          clk_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_GAP) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    spi_state_t            state;
    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [SPI_BYTE_W-1:0] sreg;
    logic [SPI_BYTE_W-1:0] win_byte;

    logic                  arb_vld;
    logic [NUM_REQ-1:0]    arb_oh;
    logic [IDX_W-1:0]      arb_idx;
    logic                  grant_en;
    logic                  half_end;
    logic                  bit_adv;

    function automatic logic first_bit(input logic [SPI_BYTE_W-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[SPI_BYTE_W-1];
    endfunction

    function automatic logic [SPI_BYTE_W-1:0] shift_byte(input logic [SPI_BYTE_W-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    spi_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .adv    (grant_en),
        .vld    (arb_vld),
        .win_oh (arb_oh),
        .win_idx(arb_idx)
    );

    assign grant_en = (state == ST_IDLE) && arb_vld;
    assign half_end = (state == ST_SHIFT) && (div_cnt == DIV_LAST);
    // A new bit goes out only as clk_out falls, never after the eighth bit.
    assign bit_adv  = half_end && clk_out && (bit_cnt != 3'd7);

    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (arb_idx == IDX_W'(k))
                win_byte = data[SPI_BYTE_W*k +: SPI_BYTE_W];
    end

    always_ff @(posedge clk) begin
        if (grant_en)
            sreg <= win_byte;
        else if (bit_adv)
            sreg <= shift_byte(sreg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= 1'b0;
            en_out  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        gnt     <= arb_oh;
                        gnt_id  <= arb_idx;
                        out     <= first_bit(win_byte);
                        en_out  <= 1'b1;
                        busy    <= 1'b1;
                        clk_out <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        if (!clk_out) begin
                            clk_out <= 1'b1;
                        end else begin
                            clk_out <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                en_out  <= 1'b0;
                                out     <= 1'b0;
                                done    <= 1'b1;
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                out     <= first_bit(shift_byte(sreg));
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
